// File: rtl/move_list_scan_pkg.sv
// Shared types for the move-list scanner: UCI field layout, scan FSM states
// and the default move-index width.
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 256
`endif

package move_list_scan_pkg;

  localparam int MAX_POSITIONS_LOG2_DEF = $clog2(`MAX_POSITIONS);

  localparam int UCI_SQ_W          = 3;
  localparam int UCI_PROMO_W       = 4;
  localparam int UCI_FROM_COL_LSB  = 0;
  localparam int UCI_FROM_ROW_LSB  = 3;
  localparam int UCI_TO_COL_LSB    = 6;
  localparam int UCI_TO_ROW_LSB    = 9;
  localparam int UCI_PROMO_LSB     = 12;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_FETCH      = 3'd2,
    S_WAIT_DATA  = 3'd3,
    S_COMPARE    = 3'd4,
    S_CLEAR      = 3'd5,
    S_CLEAR_WAIT = 3'd6,
    S_DONE       = 3'd7
  } scan_state_e;

  function automatic logic [15:0] uci_pack(
    input logic [UCI_SQ_W-1:0]    from_col,
    input logic [UCI_SQ_W-1:0]    from_row,
    input logic [UCI_SQ_W-1:0]    to_col,
    input logic [UCI_SQ_W-1:0]    to_row,
    input logic [UCI_PROMO_W-1:0] promo
  );
    logic [15:0] u;
    u = 16'h0000;
    u[UCI_FROM_COL_LSB +: UCI_SQ_W]  = from_col;
    u[UCI_FROM_ROW_LSB +: UCI_SQ_W]  = from_row;
    u[UCI_TO_COL_LSB   +: UCI_SQ_W]  = to_col;
    u[UCI_TO_ROW_LSB   +: UCI_SQ_W]  = to_row;
    u[UCI_PROMO_LSB    +: UCI_PROMO_W] = promo;
    return u;
  endfunction

endpackage

// File: rtl/move_list_scan_if.sv
// Control/data bundle between the scanner, all_moves and the search logic.
// master is the scanner's view; slave is the surrounding environment.
interface move_list_scan_if
  import move_list_scan_pkg::*;
#(
  parameter int MAX_POSITIONS_LOG2 = MAX_POSITIONS_LOG2_DEF,
  parameter int EVAL_WIDTH         = 22,
  parameter int UCI_WIDTH          = 16
);
  logic                          start;
  logic                          white_to_move_in;
  logic                          am_moves_ready;
  logic [MAX_POSITIONS_LOG2-1:0] am_move_count;
  logic signed [EVAL_WIDTH-1:0]  eval_out;
  logic [UCI_WIDTH-1:0]          uci_out;
  logic                          initial_mate;
  logic                          initial_stalemate;
  logic [MAX_POSITIONS_LOG2-1:0] am_move_index;
  logic                          am_clear_moves;
  logic                          busy;
  logic                          done;
  logic                          no_moves;
  logic                          mate_out;
  logic                          stalemate_out;
  logic [MAX_POSITIONS_LOG2-1:0] best_index;
  logic [UCI_WIDTH-1:0]          best_uci;
  logic signed [EVAL_WIDTH-1:0]  best_eval;

  modport master (
    input  start, white_to_move_in, am_moves_ready, am_move_count,
           eval_out, uci_out, initial_mate, initial_stalemate,
    output am_move_index, am_clear_moves, busy, done, no_moves,
           mate_out, stalemate_out, best_index, best_uci, best_eval
  );

  modport slave (
    output start, white_to_move_in, am_moves_ready, am_move_count,
           eval_out, uci_out, initial_mate, initial_stalemate,
    input  am_move_index, am_clear_moves, busy, done, no_moves,
           mate_out, stalemate_out, best_index, best_uci, best_eval
  );
endinterface

// File: rtl/move_list_scan.sv
// Walks the all_moves list through a fixed-latency RAM, keeps the best move
// for the side to move, then clears all_moves and pulses done.
module move_list_scan
  import move_list_scan_pkg::*;
#(
  parameter int MAX_POSITIONS_LOG2 = MAX_POSITIONS_LOG2_DEF,
  parameter int EVAL_WIDTH         = 22,
  parameter int UCI_WIDTH          = 16,
  parameter int READ_LATENCY       = 2
) (
  input logic              clk,
  input logic              reset,
  move_list_scan_if.master bus
);
  localparam int         IW       = MAX_POSITIONS_LOG2;
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  scan_state_e                  state_q, state_d;
  logic                         white_q, white_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [IW-1:0]                count_q, count_d;
  logic [1:0]                   lat_q, lat_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         clear_q, clear_d;
  logic                         no_moves_q, no_moves_d;
  logic                         mate_q, mate_d;
  logic                         stale_q, stale_d;
  logic [IW-1:0]                best_idx_q, best_idx_d;
  logic [UCI_WIDTH-1:0]         best_uci_q, best_uci_d;
  logic signed [EVAL_WIDTH-1:0] best_eval_q, best_eval_d;
  logic signed [EVAL_WIDTH-1:0] eval_s;
  logic [IW:0]                  idx_next_s;
  logic                         better_s;

  assign eval_s = bus.eval_out;
  // One extra bit so a full-size list cannot wrap the index.
  assign idx_next_s = {1'b0, idx_q} + {{IW{1'b0}}, 1'b1};
  assign better_s   = white_q ? (eval_s > best_eval_q) : (eval_s < best_eval_q);

  // Next-state and next-value logic for the scan FSM and result registers.
  always_comb begin
    state_d     = state_q;
    white_d     = white_q;
    idx_d       = idx_q;
    count_d     = count_q;
    lat_d       = lat_q;
    busy_d      = busy_q;
    no_moves_d  = no_moves_q;
    mate_d      = mate_q;
    stale_d     = stale_q;
    best_idx_d  = best_idx_q;
    best_uci_d  = best_uci_q;
    best_eval_d = best_eval_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          white_d    = bus.white_to_move_in;
          busy_d     = 1'b1;
          no_moves_d = 1'b0;
          mate_d     = 1'b0;
          stale_d    = 1'b0;
          idx_d      = {IW{1'b0}};
          state_d    = S_WAIT_READY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_READY: begin
        if (bus.am_moves_ready) begin
          count_d = bus.am_move_count;
          mate_d  = bus.initial_mate;
          stale_d = bus.initial_stalemate;
          if (bus.am_move_count == {IW{1'b0}}) begin
            no_moves_d  = 1'b1;
            best_idx_d  = {IW{1'b0}};
            best_uci_d  = {UCI_WIDTH{1'b0}};
            best_eval_d = {EVAL_WIDTH{1'b0}};
            state_d     = S_CLEAR;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_WAIT_READY;
        end
      end
      S_FETCH: begin
        lat_d   = LAT_LOAD;
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (lat_q == 2'd0) begin
          state_d = S_COMPARE;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_COMPARE: begin
        if ((idx_q == {IW{1'b0}}) || better_s) begin
          best_idx_d  = idx_q;
          best_uci_d  = bus.uci_out;
          best_eval_d = eval_s;
        end else begin
          best_idx_d = best_idx_q;
        end
        if (idx_next_s < {1'b0, count_q}) begin
          idx_d   = idx_next_s[IW-1:0];
          state_d = S_FETCH;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        idx_d   = {IW{1'b0}};
        state_d = S_CLEAR_WAIT;
      end
      S_CLEAR_WAIT: state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    // Pulses are registered from the state being entered so they align with it.
    done_d  = (state_d == S_DONE);
    clear_d = (state_d == S_CLEAR);
    if (state_d == S_DONE) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_d;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      white_q     <= 1'b0;
      idx_q       <= {IW{1'b0}};
      count_q     <= {IW{1'b0}};
      lat_q       <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clear_q     <= 1'b0;
      no_moves_q  <= 1'b0;
      mate_q      <= 1'b0;
      stale_q     <= 1'b0;
      best_idx_q  <= {IW{1'b0}};
      best_uci_q  <= {UCI_WIDTH{1'b0}};
      best_eval_q <= {EVAL_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      white_q     <= white_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      lat_q       <= lat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clear_q     <= clear_d;
      no_moves_q  <= no_moves_d;
      mate_q      <= mate_d;
      stale_q     <= stale_d;
      best_idx_q  <= best_idx_d;
      best_uci_q  <= best_uci_d;
      best_eval_q <= best_eval_d;
    end
  end

  assign bus.am_move_index  = idx_q;
  assign bus.am_clear_moves = clear_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.no_moves       = no_moves_q;
  assign bus.mate_out       = mate_q;
  assign bus.stalemate_out  = stale_q;
  assign bus.best_index     = best_idx_q;
  assign bus.best_uci       = best_uci_q;
  assign bus.best_eval      = best_eval_q;

endmodule

// File: tb/tb_move_list_scan.sv
// Scoreboard bench: two scanners (read latency 2 and 1) share stimulus, each
// with its own lagging move-RAM model and an all_moves-style ready flag.
module tb_move_list_scan;
  import move_list_scan_pkg::*;

  localparam int IW = 4;
  localparam int EW = 22;
  localparam int UW = 16;
  localparam int NMAX = 16;

  typedef struct {
    int idx; int uci; int eval;
    bit no_moves; bit mate; bit stale;
    int cycles; int max_idx;
  } exp_t;

  typedef struct {
    logic busy, done, clr, rdy, nm, mt, st;
    logic [IW-1:0] idx, bidx;
    logic [UW-1:0] buci;
    logic signed [EW-1:0] beval;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0, white = 1'b0, mate = 1'b0, stale = 1'b0, arm = 1'b0;
  logic [IW-1:0] count = '0;
  logic signed [EW-1:0] ev_mem [NMAX];
  logic [UW-1:0]        uc_mem [NMAX];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int  rdy_cyc[2], clr_cnt[2], max_idx[2];
  bit  rdy_seen[2], done_seen[2];

  move_list_scan_if #(.MAX_POSITIONS_LOG2(IW), .EVAL_WIDTH(EW), .UCI_WIDTH(UW)) bus0();
  move_list_scan_if #(.MAX_POSITIONS_LOG2(IW), .EVAL_WIDTH(EW), .UCI_WIDTH(UW)) bus1();

  move_list_scan #(.MAX_POSITIONS_LOG2(IW), .EVAL_WIDTH(EW), .UCI_WIDTH(UW), .READ_LATENCY(2))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  move_list_scan #(.MAX_POSITIONS_LOG2(IW), .EVAL_WIDTH(EW), .UCI_WIDTH(UW), .READ_LATENCY(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic rdy0 = 1'b0, rdy1 = 1'b0;
  logic signed [EW-1:0] e0a = '0, e0b = '0, e1a = '0;
  logic [UW-1:0]        u0a = '0, u0b = '0, u1a = '0;

  // all_moves model: ready until cleared, RAM data lagging the index by the latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || bus0.am_clear_moves) rdy0 <= 1'b0;
    else if (arm) rdy0 <= 1'b1;
    if (reset || bus1.am_clear_moves) rdy1 <= 1'b0;
    else if (arm) rdy1 <= 1'b1;
    e0a <= ev_mem[bus0.am_move_index]; e0b <= e0a;
    u0a <= uc_mem[bus0.am_move_index]; u0b <= u0a;
    e1a <= ev_mem[bus1.am_move_index];
    u1a <= uc_mem[bus1.am_move_index];
  end

  assign bus0.start = start;              assign bus1.start = start;
  assign bus0.white_to_move_in = white;   assign bus1.white_to_move_in = white;
  assign bus0.am_moves_ready = rdy0;      assign bus1.am_moves_ready = rdy1;
  assign bus0.am_move_count = count;      assign bus1.am_move_count = count;
  assign bus0.initial_mate = mate;        assign bus1.initial_mate = mate;
  assign bus0.initial_stalemate = stale;  assign bus1.initial_stalemate = stale;
  assign bus0.eval_out = e0b;             assign bus1.eval_out = e1a;
  assign bus0.uci_out = u0b;              assign bus1.uci_out = u1a;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic grab(input int k, output obs_t o);
    if (k == 0) begin
      o.busy = bus0.busy; o.done = bus0.done; o.clr = bus0.am_clear_moves; o.rdy = rdy0;
      o.nm = bus0.no_moves; o.mt = bus0.mate_out; o.st = bus0.stalemate_out;
      o.idx = bus0.am_move_index; o.bidx = bus0.best_index;
      o.buci = bus0.best_uci; o.beval = bus0.best_eval;
    end else begin
      o.busy = bus1.busy; o.done = bus1.done; o.clr = bus1.am_clear_moves; o.rdy = rdy1;
      o.nm = bus1.no_moves; o.mt = bus1.mate_out; o.st = bus1.stalemate_out;
      o.idx = bus1.am_move_index; o.bidx = bus1.best_index;
      o.buci = bus1.best_uci; o.beval = bus1.best_eval;
    end
  endtask

  task automatic check_zero(input int k);
    obs_t o;
    grab(k, o);
    check_eq($sformatf("d%0d_rst_busy", k), o.busy, 0);
    check_eq($sformatf("d%0d_rst_done", k), o.done, 0);
    check_eq($sformatf("d%0d_rst_clear", k), o.clr, 0);
    check_eq($sformatf("d%0d_rst_index", k), o.idx, 0);
    check_eq($sformatf("d%0d_rst_no_moves", k), o.nm, 0);
    check_eq($sformatf("d%0d_rst_mate", k), o.mt, 0);
    check_eq($sformatf("d%0d_rst_stalemate", k), o.st, 0);
    check_eq($sformatf("d%0d_rst_best_index", k), o.bidx, 0);
    check_eq($sformatf("d%0d_rst_best_uci", k), o.buci, 0);
    check_eq($sformatf("d%0d_rst_best_eval", k), o.beval, 0);
  endtask

  task automatic reset_obs();
    for (int k = 0; k < 2; k++) begin
      rdy_seen[k] = 1'b0; done_seen[k] = 1'b0;
      clr_cnt[k] = 0; max_idx[k] = 0; rdy_cyc[k] = 0;
    end
  endtask

  task automatic set_move(input int i, input int v);
    ev_mem[i] = EW'(v);
    uc_mem[i] = uci_pack(3'(i), 3'(i >> 3), 3'(7 - (i % 8)), 3'(i % 5), 4'(i % 3));
  endtask

  task automatic push_expected(input bit w, input int n, input bit m, input bit s);
    exp_t e;
    int b = 0;
    for (int i = 1; i < n; i++) begin
      if (w ? (int'(ev_mem[i]) > int'(ev_mem[b])) : (int'(ev_mem[i]) < int'(ev_mem[b]))) b = i;
    end
    e.idx = b;
    e.uci = (n == 0) ? 0 : int'(uc_mem[b]);
    e.eval = (n == 0) ? 0 : int'(ev_mem[b]);
    e.no_moves = (n == 0); e.mate = m; e.stale = s;
    e.max_idx = (n == 0) ? 0 : n - 1;
    e.cycles = 1 + n * (2 + 2) + 3; q0.push_back(e);
    e.cycles = 1 + n * (1 + 2) + 3; q1.push_back(e);
  endtask

  task automatic observe();
    obs_t o;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      grab(k, o);
      if (o.rdy === 1'b1 && !rdy_seen[k]) begin rdy_seen[k] = 1'b1; rdy_cyc[k] = cyc; end
      if (o.clr === 1'b1) clr_cnt[k]++;
      if (o.busy === 1'b1 && int'(o.idx) > max_idx[k]) max_idx[k] = int'(o.idx);
      if (o.done === 1'b1 && !done_seen[k]) begin
        done_seen[k] = 1'b1;
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          check_eq($sformatf("d%0d_sb_nonempty", k), 0, 1);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check_eq($sformatf("d%0d_best_index", k), o.bidx, e.idx);
          check_eq($sformatf("d%0d_best_uci", k), o.buci, e.uci);
          check_eq($sformatf("d%0d_best_eval", k), o.beval, e.eval);
          check_eq($sformatf("d%0d_no_moves", k), o.nm, e.no_moves);
          check_eq($sformatf("d%0d_mate", k), o.mt, e.mate);
          check_eq($sformatf("d%0d_stalemate", k), o.st, e.stale);
          check_eq($sformatf("d%0d_busy_at_done", k), o.busy, 0);
          check_eq($sformatf("d%0d_cycles", k), cyc - rdy_cyc[k] + 1, e.cycles);
          check_eq($sformatf("d%0d_clear_pulses", k), clr_cnt[k], 1);
          check_eq($sformatf("d%0d_max_index", k), max_idx[k], e.max_idx);
        end
      end
    end
  endtask

  task automatic run_scan(input bit w, input int n, input bit m, input bit s, input bit poke);
    obs_t o;
    reset_obs();
    push_expected(w, n, m, s);
    @(negedge clk); start = 1'b1; white = w;
    @(negedge clk); start = 1'b0; white = ~w;
    count = IW'(n); mate = m; stale = s; arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    for (int t = 0; t < 400 && !(done_seen[0] && done_seen[1]); t++) begin
      start = (poke && t == 5);
      observe();
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("d0_done_seen", done_seen[0], 1);
    check_eq("d1_done_seen", done_seen[1], 1);
    repeat (3) @(negedge clk);
    grab(0, o);
    check_eq("d0_hold_busy", o.busy, 0);
    check_eq("d0_hold_no_moves", o.nm, (n == 0));
  endtask

  initial begin
    for (int i = 0; i < NMAX; i++) set_move(i, 0);
    repeat (3) @(negedge clk);
    check_zero(0); check_zero(1);
    reset = 1'b0;
    @(negedge clk);

    set_move(0, 10); set_move(1, -5); set_move(2, 40);
    run_scan(1'b1, 3, 1'b0, 1'b0, 1'b0);

    set_move(0, 7); set_move(1, -3); set_move(2, -3); set_move(3, 20);
    run_scan(1'b0, 4, 1'b0, 1'b0, 1'b1);

    run_scan(1'b1, 0, 1'b1, 1'b0, 1'b0);
    run_scan(1'b0, 0, 1'b0, 1'b1, 1'b0);

    set_move(0, -(1 << 21)); set_move(1, (1 << 21) - 1); set_move(2, 0);
    run_scan(1'b1, 3, 1'b0, 1'b0, 1'b0);
    set_move(0, (1 << 21) - 1); set_move(1, -(1 << 21)); set_move(2, -(1 << 21));
    run_scan(1'b0, 3, 1'b0, 1'b0, 1'b0);

    // Abort a scan in WAIT_DATA of the latency-2 scanner.
    reset_obs();
    @(negedge clk); start = 1'b1; white = 1'b1;
    @(negedge clk); start = 1'b0; count = IW'(3); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    observe(); @(negedge clk);
    observe(); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero(0); check_zero(1);
    reset = 1'b0;
    for (int t = 0; t < 20; t++) begin observe(); @(negedge clk); end
    check_eq("d0_no_clear_after_abort", clr_cnt[0], 0);
    check_eq("d1_no_clear_after_abort", clr_cnt[1], 0);

    set_move(0, 1); set_move(1, 2);
    run_scan(1'b1, 2, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NMAX; i++) set_move(i, int'($urandom_range(0, 4000)) - 2000);
    run_scan(1'b1, NMAX - 1, 1'b0, 1'b0, 1'b0);
    run_scan(1'b0, NMAX - 1, 1'b0, 1'b0, 1'b0);

    check_eq("sb0_drained", q0.size(), 0);
    check_eq("sb1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
